// File: rtl/bitmap_seq_pkg.sv
// rtl/bitmap_seq_pkg.sv - shared types, defaults and width helpers for the bitmap switch sequencer
package bitmap_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  localparam int DEF_DATA_WIDTH   = 128;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_NUM_SWITCHES = 7;
  localparam int DEF_SIZE_WIDTH   = 32;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int slices_per_word(input int data_width, input int num_switches);
    return data_width / num_switches;
  endfunction

  localparam int SLICES_PER_WORD = slices_per_word(DEF_DATA_WIDTH, DEF_NUM_SWITCHES);
  localparam int PTR_WIDTH       = width_for(DEF_DEPTH);
  localparam int SLICE_WIDTH     = width_for(SLICES_PER_WORD);

endpackage

// File: rtl/bitmap_switch_sequencer_if.sv
// rtl/bitmap_switch_sequencer_if.sv - bitmap word input stream and switch slice output bundle
interface bitmap_switch_sequencer_if
  import bitmap_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_SWITCHES = DEF_NUM_SWITCHES
);

  logic [DATA_WIDTH-1:0]   in_word;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_SWITCHES-1:0] out_to_switches;
  logic                    out_valid;

  modport master (
    output in_word,
    output in_valid,
    input  in_ready,
    input  out_to_switches,
    input  out_valid
  );

  modport slave (
    input  in_word,
    input  in_valid,
    output in_ready,
    output out_to_switches,
    output out_valid
  );

endinterface

// File: rtl/bitmap_seq_buffer.sv
// rtl/bitmap_seq_buffer.sv - simple dual-port word buffer, synchronous write, registered read
module bitmap_seq_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // rd_data holds its value between reads; the sequencer relies on that.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bitmap_switch_sequencer.sv
// rtl/bitmap_switch_sequencer.sv - buffers bitmap words and plays them out as switch slices; BITMAP_SEQ_INT_SYNC_EN adds an internal sync generator
module bitmap_switch_sequencer
  import bitmap_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int NUM_SWITCHES = DEF_NUM_SWITCHES,
  parameter int SIZE_WIDTH   = DEF_SIZE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  bitmap_switch_sequencer_if.slave bus,
  input  logic [SIZE_WIDTH-1:0] in_size,
  input  logic                  start,
  input  logic                  sync,
  input  logic                  loop_mode,
  input  logic                  abort,
`ifdef BITMAP_SEQ_INT_SYNC_EN
  input  logic [15:0]           sync_period,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  size_err
);

  localparam int SLICES = slices_per_word(DATA_WIDTH, NUM_SWITCHES);
  localparam int AW     = width_for(DEPTH);
  localparam int CW     = AW + 1;
  localparam int SW     = width_for(SLICES);
  localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);

  seq_state_t state, state_n;

  logic [CW-1:0]           count;
  logic                    full;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;

  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;

  logic [AW-1:0]           word_idx;
  logic [AW-1:0]           last_idx;
  logic [AW-1:0]           next_idx;
  logic [SW-1:0]           slice_idx;
  logic [DATA_WIDTH-1:0]   cur_word;
  logic                    loop_q;
  logic                    tail_q;

  logic                    size_over;
  logic [CW-1:0]           start_cnt;
  logic                    start_zero;

  logic                    sync_eff;
  logic                    do_start;
  logic                    do_slice;
  logic                    do_end;

  logic [DATA_WIDTH-1:0]   slice_src;
  logic [DATA_WIDTH-1:0]   slice_shifted;
  int                      slice_base;
  logic [NUM_SWITCHES-1:0] slice_val;

  logic [NUM_SWITCHES-1:0] out_q;
  logic                    out_valid_q;

  assign full          = (count == CW'(DEPTH));
  assign wr_addr       = count[AW-1:0];
  assign wr_en         = (state == ST_IDLE) && bus.in_valid && !full;
  assign bus.in_ready  = (state == ST_IDLE) && !full;
  assign busy          = (state == ST_RUN);

  assign size_over     = in_size > SIZE_WIDTH'(count);
  assign start_cnt     = size_over ? count : CW'(in_size);
  assign start_zero    = (start_cnt == '0);

  assign next_idx      = (word_idx == last_idx) ? '0 : word_idx + 1'b1;

  // Slice 0 is taken straight from the prefetched read; the rest come from the captured copy.
  assign slice_src     = (slice_idx == '0) ? rd_data : cur_word;
  assign slice_base    = int'(slice_idx) * NUM_SWITCHES;
  assign slice_shifted = slice_src >> slice_base;
  assign slice_val     = slice_shifted[NUM_SWITCHES-1:0];

  assign bus.out_to_switches = out_q;
  assign bus.out_valid       = out_valid_q;

`ifdef BITMAP_SEQ_INT_SYNC_EN
  logic [15:0] sync_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_cnt <= '0;
    end else if (do_start) begin
      sync_cnt <= '0;
    end else if (state == ST_RUN) begin
      sync_cnt <= (sync_cnt == sync_period) ? '0 : sync_cnt + 1'b1;
    end
  end

  assign sync_eff = (state == ST_RUN) && (sync_cnt == sync_period);
`else
  assign sync_eff = sync;
`endif

  bitmap_seq_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_buffer (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.in_word),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    do_start = 1'b0;
    do_slice = 1'b0;
    do_end   = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = next_idx;
    case (state)
      ST_IDLE: begin
        if (start) begin
          do_start = 1'b1;
          rd_en    = 1'b1;
          rd_addr  = '0;
          if (!start_zero) begin
            state_n = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          do_end  = 1'b1;
          state_n = ST_IDLE;
        end else if (sync_eff) begin
          if (tail_q) begin
            do_end  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            do_slice = 1'b1;
            // Prefetch the following word while this one is being sliced.
            rd_en    = (slice_idx == '0);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      overflow    <= 1'b0;
      size_err    <= 1'b0;
      done        <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      word_idx    <= '0;
      last_idx    <= '0;
      slice_idx   <= '0;
      cur_word    <= '0;
      loop_q      <= 1'b0;
      tail_q      <= 1'b0;
    end else begin
      done        <= 1'b0;
      out_valid_q <= 1'b0;

      if (wr_en) begin
        count <= count + 1'b1;
      end
      if (bus.in_valid && full) begin
        overflow <= 1'b1;
      end

      if (do_start) begin
        size_err  <= size_err | size_over;
        loop_q    <= loop_mode;
        last_idx  <= AW'(start_cnt - 1'b1);
        word_idx  <= '0;
        slice_idx <= '0;
        tail_q    <= 1'b0;
        if (start_zero) begin
          done <= 1'b1;
        end
      end

      if (do_slice) begin
        out_q       <= slice_val;
        out_valid_q <= 1'b1;
        if (slice_idx == '0) begin
          cur_word <= rd_data;
        end
        if (slice_idx == LAST_SLICE) begin
          slice_idx <= '0;
          word_idx  <= next_idx;
          if (word_idx == last_idx && !loop_q) begin
            tail_q <= 1'b1;
          end
        end else begin
          slice_idx <= slice_idx + 1'b1;
        end
      end

      if (do_end) begin
        out_q  <= '0;
        done   <= 1'b1;
        tail_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_switch_sequencer.sv
// tb/tb_bitmap_switch_sequencer.sv - randomized directed bench with a slice-list reference model
module tb_bitmap_switch_sequencer;

  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int NS    = 7;
  localparam int SZW   = 32;
  localparam int S     = DW / NS;

  logic           clock = 1'b0;
  logic           reset;
  logic [SZW-1:0] in_size;
  logic           start;
  logic           sync;
  logic           loop_mode;
  logic           abort;
  logic [15:0]    sync_period;
  logic           busy;
  logic           done;
  logic           overflow;
  logic           size_err;

  always #5 clock = ~clock;

  bitmap_switch_sequencer_if #(.DATA_WIDTH(DW), .NUM_SWITCHES(NS)) bus ();

  bitmap_switch_sequencer #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .NUM_SWITCHES (NS),
    .SIZE_WIDTH   (SZW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .in_size     (in_size),
    .start       (start),
    .sync        (sync),
    .loop_mode   (loop_mode),
    .abort       (abort),
`ifdef BITMAP_SEQ_INT_SYNC_EN
    .sync_period (sync_period),
`endif
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .size_err    (size_err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];
  int            mcount;
  logic [NS-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_word  = '0;
    bus.in_valid = 1'b0;
    in_size      = '0;
    start        = 1'b0;
    sync         = 1'b0;
    loop_mode    = 1'b0;
    abort        = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    mcount = 0;
    exp_q.delete();
  endtask

  task automatic load(input logic [DW-1:0] w);
    bus.in_word  = w;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (mcount < DEPTH) begin
      mem[mcount] = w;
      mcount++;
    end
  endtask

  // Expected playback is the flat list of every slice of every played word, in order.
  task automatic start_play(input int size, input bit lp);
    int eff;
    logic [DW-1:0] t;
    in_size   = SZW'(size);
    loop_mode = lp;
    start     = 1'b1;
    tick();
    start = 1'b0;
    eff = (size < mcount) ? size : mcount;
    exp_q.delete();
    for (int w = 0; w < eff; w++) begin
      for (int k = 0; k < S; k++) begin
        t = mem[w] >> (k * NS);
        exp_q.push_back(t[NS-1:0]);
      end
    end
  endtask

  task automatic sync_once();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  initial begin
    sync_period = 16'd0;

    // Reset state
    do_reset();
    chk("rst_out", bus.out_to_switches, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_size_err", size_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);

`ifndef BITMAP_SEQ_INT_SYNC_EN
    // Known word, two slices
    load(128'h2824d792ce7c5856f1222b25bb92f5df);
    start_play(1, 1'b0);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready_run", bus.in_ready, 0);
    chk("t1_idle_out_valid", bus.out_valid, 0);
    sync_once();
    chk("t1_slice0", bus.out_to_switches, 7'h5F);
    chk("t1_valid0", bus.out_valid, 1);
    tick();
    chk("t1_valid_pulse", bus.out_valid, 0);
    sync_once();
    chk("t1_slice1", bus.out_to_switches, 7'h6B);
    chk("t1_valid1", bus.out_valid, 1);

    // Four words, back-to-back syncs, no loop
    do_reset();
    for (int i = 0; i < 4; i++) load(rand_word());
    start_play(4, 1'b0);
    sync = 1'b1;
    for (int i = 0; i < 4 * S; i++) begin
      tick();
      chk($sformatf("t2_slice%0d", i), bus.out_to_switches, exp_q[i]);
      chk($sformatf("t2_valid%0d", i), bus.out_valid, 1);
      chk($sformatf("t2_nodone%0d", i), done, 0);
    end
    tick();
    sync = 1'b0;
    chk("t2_end_out", bus.out_to_switches, 0);
    chk("t2_end_done", done, 1);
    chk("t2_end_busy", busy, 0);
    tick();
    chk("t2_done_pulse", done, 0);

    // Two words, loop mode with random gaps, then abort beating a same-cycle sync
    do_reset();
    for (int i = 0; i < 2; i++) load(rand_word());
    start_play(2, 1'b1);
    for (int i = 0; i < 40; i++) begin
      sync_once();
      chk($sformatf("t3_slice%0d", i), bus.out_to_switches, exp_q[i % (2 * S)]);
      chk($sformatf("t3_nodone%0d", i), done, 0);
      if (i == 2 * S) chk("t3_wrap_word0", bus.out_to_switches, exp_q[0]);
      repeat ($urandom_range(0, 2)) tick();
    end
    chk("t3_busy_loop", busy, 1);
    abort = 1'b1;
    sync  = 1'b1;
    tick();
    abort = 1'b0;
    sync  = 1'b0;
    chk("t3_abort_out", bus.out_to_switches, 0);
    chk("t3_abort_done", done, 1);
    chk("t3_abort_busy", busy, 0);
    chk("t3_abort_valid", bus.out_valid, 0);
    tick();
    chk("t3_abort_done_pulse", done, 0);

    // Overflow on the 17th write, oversize request plays the whole buffer
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      load(rand_word());
      chk($sformatf("t4_in_ready%0d", i), bus.in_ready, (i < DEPTH) ? 1 : 0);
      chk($sformatf("t4_overflow%0d", i), overflow, (i > DEPTH) ? 1 : 0);
    end
    start_play(20, 1'b0);
    chk("t4_size_err", size_err, 1);
    chk("t4_busy", busy, 1);
    for (int i = 0; i < DEPTH * S; i++) begin
      sync_once();
      chk($sformatf("t4_slice%0d", i), bus.out_to_switches, exp_q[i]);
    end
    sync_once();
    chk("t4_end_done", done, 1);
    chk("t4_end_out", bus.out_to_switches, 0);
    start_play(1, 1'b0);
    sync_once();
    chk("t4_replay_slice0", bus.out_to_switches, exp_q[0]);
    sync_once();
    chk("t4_replay_slice1", bus.out_to_switches, exp_q[1]);
    chk("t4_size_err_sticky", size_err, 1);

    // Zero-size start, then reset in the middle of a run
    do_reset();
    load(rand_word());
    start_play(0, 1'b0);
    chk("t5_zero_done", done, 1);
    chk("t5_zero_busy", busy, 0);
    chk("t5_zero_valid", bus.out_valid, 0);
    chk("t5_zero_size_err", size_err, 0);
    tick();
    chk("t5_zero_done_pulse", done, 0);
    start_play(1, 1'b1);
    sync_once();
    chk("t5_run_slice0", bus.out_to_switches, exp_q[0]);
    sync_once();
    reset = 1'b1;
    tick();
    chk("t5_rst_out", bus.out_to_switches, 0);
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    reset = 1'b0;
    tick();
    chk("t5_after_rst_done", done, 0);
    chk("t5_after_rst_in_ready", bus.in_ready, 1);
`else
    // Internal sync generator, one slice every four cycles
    begin
      int last_cyc;
      int n;
      last_cyc = -1;
      n = 0;
      for (int i = 0; i < 2; i++) load(rand_word());
      sync_period = 16'd3;
      start_play(2, 1'b1);
      for (int cyc = 0; cyc < 40; cyc++) begin
        tick();
        if (bus.out_valid === 1'b1) begin
          chk($sformatf("t6_slice%0d", n), bus.out_to_switches, exp_q[n % (2 * S)]);
          if (last_cyc >= 0) chk($sformatf("t6_gap%0d", n), cyc - last_cyc, 4);
          last_cyc = cyc;
          n++;
        end
      end
      chk("t6_pulse_count_ok", (n >= 9) ? 1 : 0, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t6_abort_done", done, 1);
      chk("t6_abort_out", bus.out_to_switches, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
